// File: rtl/serial_word_pkg.sv
// Shared types and helpers for the serial word port.
// Provides the FSM state encoding, width limits and a width-aware bit reverser.
package serial_word_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MAX_WIDTH     = 256;
  localparam int unsigned MAX_IDX_W     = 8;
  localparam int unsigned GAP_CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_GAP    = 2'd2,
    S_PARITY = 2'd3
  } state_e;

  // Reverses the low 'width' bits of 'word'; bits at and above 'width' return 0.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] word,
                                                        input int unsigned width);
    logic [MAX_WIDTH-1:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) rev[MAX_IDX_W'(i)] = word[MAX_IDX_W'(width - 1 - i)];
    end
    return rev;
  endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// Load/shift register with beat counter for the serial word port.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   load_i        - load load_word_i and preset the counter to WIDTH-1 (wins over shift_i)
//   shift_i       - shift right by one, fill_i enters at the MSB, counter decrements
//   fill_i        - bit shifted into the MSB
//   load_word_i   - word to load (already in transmit order)
//   bit_o         - register bit 0, the current serial bit
//   last_o        - counter is 0 (current bit is the last data bit)
//   first_nxt_o   - counter will be WIDTH-1 after this edge
//   last_nxt_o    - counter will be 0 after this edge
module serial_word_shifter
  import serial_word_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] load_word_i,
  output logic             bit_o,
  output logic             last_o,
  output logic             first_nxt_o,
  output logic             last_nxt_o
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: load has priority so a final beat and a new accept can share an edge.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_word_i;
      cnt_d = CNT_TOP;
    end else if (shift_i) begin
      sr_d = {fill_i, sr_q[WIDTH-1:1]};
      // Counter parks at 0 after the last beat instead of wrapping.
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o       = sr_q[0];
  assign last_o      = (cnt_q == '0);
  assign first_nxt_o = (cnt_d == CNT_TOP);
  assign last_nxt_o  = (cnt_d == '0);

endmodule

// File: rtl/serial_word_port.sv
// Parallel-to-serial word transmitter with per-word bit-order selection.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// beat on a valid/ready serial interface, LSB-first or MSB-first per word.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   word_in, word_valid     - parallel word and its valid
//   lsb_first               - 1: bit 0 first, 0: bit WIDTH-1 first (captured at accept)
//   word_ready              - word can be accepted this cycle
//   bit_out, bit_valid      - serial bit and its valid
//   bit_ready               - downstream consumes bit_out this cycle
//   sof, eof                - first / last bit of a word
//   busy                    - state is not IDLE
// Build option: define SERIAL_WORD_PORT_PARITY_EN to append an even-parity bit
// (XOR of the accepted word) after the data bits; eof then marks the parity bit
// and the back-to-back accept path is disabled.
module serial_word_port
  import serial_word_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  input  logic             lsb_first,
  output logic             word_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH || GAP > 15) begin : g_param_check
    $error("serial_word_port: WIDTH must be 2..%0d and GAP 0..15", MAX_WIDTH);
  end

`ifdef SERIAL_WORD_PORT_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam bit                   GAP_EN   = (GAP != 0);
  localparam bit                   B2B_EN   = !GAP_EN && !PARITY_EN;
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP - 1);

  state_e                 state_q, state_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   bit_valid_q, bit_valid_d;
  logic                   sof_q, sof_d;
  logic                   eof_q, eof_d;
  logic                   busy_q, busy_d;

  logic                   ready_c, accept_c, beat_c;
  logic                   load_c, shift_c, fill_c;
  logic                   last_c, first_nxt_c, last_nxt_c;
  logic [WIDTH-1:0]       load_word_c;

  // Reversal sits in the load path so the shifter always shifts right.
  assign load_word_c = lsb_first ? word_in
                                 : WIDTH'(bit_reverse(MAX_WIDTH'(word_in), WIDTH));

`ifdef SERIAL_WORD_PORT_PARITY_EN
  logic parity_q;

  // Every shift fills with the parity bit, so after WIDTH shifts bit 0 holds it.
  assign fill_c = parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        parity_q <= 1'b0;
    else if (accept_c) parity_q <= ^word_in;
  end
`else
  assign fill_c = 1'b0;
`endif

  serial_word_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_c),
    .shift_i     (shift_c),
    .fill_i      (fill_c),
    .load_word_i (load_word_c),
    .bit_o       (bit_out),
    .last_o      (last_c),
    .first_nxt_o (first_nxt_c),
    .last_nxt_o  (last_nxt_c)
  );

  // Handshake decode and next-state / next-output logic.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    ready_c  = 1'b0;
    load_c   = 1'b0;
    shift_c  = 1'b0;

    case (state_q)
      S_IDLE:  ready_c = 1'b1;
      S_SHIFT: ready_c = B2B_EN && last_c && bit_ready;
      default: ready_c = 1'b0;
    endcase

    accept_c = word_valid && ready_c;
    beat_c   = bit_valid_q && bit_ready;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_SHIFT;
          load_c  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (beat_c) begin
          shift_c = 1'b1;
          if (last_c) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
            end else if (GAP_EN) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end else if (accept_c) begin
              state_d = S_SHIFT;
              load_c  = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GAP_CNT_W'(1);
      end
      S_PARITY: begin
        if (beat_c) begin
          if (GAP_EN) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    bit_valid_d = (state_d == S_SHIFT) || (state_d == S_PARITY);
    busy_d      = (state_d != S_IDLE);
    sof_d       = (state_d == S_SHIFT) && first_nxt_c;
    eof_d       = PARITY_EN ? (state_d == S_PARITY)
                            : ((state_d == S_SHIFT) && last_nxt_c);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
    end
  end

  assign word_ready = ready_c;
  assign bit_valid  = bit_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign busy       = busy_q;

endmodule

// File: doc/serial_word_port.md
Name: serial_word_port

Overview:
Parallel-to-serial word transmitter with per-word bit-order selection.
- Generalises the fixed 32-bit combinational reverser into a parametrised, handshaked, sequential block.
- Takes a WIDTH-bit word and emits it one bit per accepted beat, either LSB-first (Baby store/line order) or MSB-first.
- Sits between the store/accumulator datapath and the serial display/CRT-line and test-link logic.

Parameters:
WIDTH, 32, word width in bits; must be 2 or more.
GAP, 0, idle cycles forced between the last bit of one word and the next word acceptance; range 0..15.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
word_in  input  WIDTH  parallel word to transmit.
word_valid  input  1  word_in and lsb_first are valid.
lsb_first  input  1  order select, sampled with the word: 1 = bit 0 first, 0 = bit WIDTH-1 first.
word_ready  output  1  block can accept a word this cycle.
bit_out  output  1  current serial bit.
bit_valid  output  1  bit_out is valid.
bit_ready  input  1  downstream consumes bit_out this cycle.
sof  output  1  high with the first bit of a word.
eof  output  1  high with the last bit of a word.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register 0, bit counter 0, gap counter 0. Outputs: bit_out 0, bit_valid 0, sof 0, eof 0, busy 0, word_ready 1 after release.
- Word accept: word_valid && word_ready on a rising edge.
  - On accept, the shift register loads word_in if lsb_first=1, else the bit-reversed word_in. Reversal is combinational in the load path.
  - Counter loads WIDTH-1.
- Bit beat: bit_valid && bit_ready.
  - On a beat, the shift register shifts right by one and the counter decrements.
  - bit_out is always shift register bit 0.
- Latency: the first bit is valid the cycle after accept. There is no combinational path from word_valid to bit_out.
- bit_valid holds while bit_ready is low. bit_out, sof and eof stay stable during a stall (AXI-style: bit_valid never drops without a beat).
- sof is high while counter == WIDTH-1 in SHIFT. eof is high while counter == 0 in SHIFT (or the parity beat if enabled).
- FSM states: IDLE, SHIFT, GAP (and PARITY if enabled).
  - IDLE: word_ready=1, bit_valid=0. Accept goes to SHIFT.
  - SHIFT: bit_valid=1. A beat with counter==0 goes to GAP if GAP>0, else to IDLE.
  - GAP: bit_valid=0, word_ready=0. Counter runs GAP cycles, then goes to IDLE.
- Back-to-back (GAP==0, parity disabled): word_ready is also high in SHIFT when counter==0 && bit_ready.
  - A simultaneous final beat and accept goes straight to SHIFT with the new word.
  - There are no bubble cycles, so the sustained rate is one bit per clock.
- word_in changes while busy and not ready are ignored.
- lsb_first is captured only at accept, so changing it mid-word has no effect.
- Reset asserted mid-word aborts the word. No eof is produced and no partial state is retained.
- Counter width is $clog2(WIDTH). Gap counter width is 4 bits.

Optional Feature:
SERIAL_WORD_PORT_PARITY_EN
- Defined: after the last data bit, a PARITY state emits one extra bit equal to the even parity (XOR reduction) of the accepted word_in. The reduction is computed at accept and stored.
  - eof moves to the parity bit; the last data bit has eof=0.
  - The back-to-back path is disabled, so there is one IDLE cycle minimum between words.
- Undefined: no PARITY state and no parity register; behaviour exactly as above.

Decomposition:
- Package serial_word_pkg:
  - typedef enum of FSM states: S_IDLE, S_SHIFT, S_GAP, S_PARITY.
  - function bit_reverse(word), parametrised by WIDTH via a typedef or a width argument.
  - localparam DEFAULT_WIDTH = 32.
- One sub-module: serial_word_shifter (WIDTH-bit load/shift register with counter, load and shift enables, and bit_out/last flags). The FSM and handshake stay in the top level.

Test Plan:
- LSB-first, WIDTH=32, GAP=0, bit_ready=1: word 32'h0000_0001 -> bit_out sequence 1 then 31 zeros; sof on beat 0, eof on beat 31; word_ready high on beat 31.
- MSB-first, same word -> 31 zeros then 1. Word 32'h8000_0003 MSB-first -> 1, 29 zeros, 1, 1.
- Back-to-back, GAP=0: words 32'hFFFF_0000 then 32'h0000_FFFF both LSB-first -> 64 consecutive beats, bit_valid never low, second sof on the cycle after the first eof.
- Stall: drop bit_ready for 5 cycles at beat 10 -> bit_out, sof and eof stable, counter frozen, remaining 22 bits correct, total word time 37 cycles.
- GAP=3: two words -> exactly 3 cycles with busy=1 and bit_valid=0 between eof and the next accept.
- Reset mid-word: assert rst_n low at beat 15 -> all outputs 0 immediately. After release, word_ready=1 and the next word transmits from its first bit. With PARITY_EN, 32'h0000_0007 -> parity bit 1 with eof.
